// File: rtl/apb_i2c_arbiter.sv
// Two-requester round-robin APB master in front of the I2C core's APB slave port.
// One transfer at a time: SETUP, then ACCESS until PREADY or the PREADY timeout
// expires, then a one-cycle response to whichever requester was granted.
//
// state  | meaning
// IDLE   | no transfer; arbitrate and accept one request
// SETUP  | PSELx=1, PENABLE=0, address/data driven from the latch
// ACCESS | PSELx=1, PENABLE=1, waiting for PREADY or timeout
// RESP   | rvalid pulse to the granted requester, rr pointer flips
module apb_i2c_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             gnt_id;
    logic             rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             sel_id;
    logic             accept;

    // Arbitration: a lone requester wins outright, contention goes to rr_ptr.
    // Ready is gated by PRESETn so nothing reports an accept while in reset.
    always_comb begin
        sel_id = rr_ptr;
        if (req0_valid && !req1_valid) begin
            sel_id = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            sel_id = 1'b1;
        end
        accept     = (state == IDLE) && PRESETn && (req0_valid || req1_valid);
        req0_ready = accept && !sel_id;
        req1_ready = accept && sel_id;
    end

    assign PSELx       = (state == SETUP) || (state == ACCESS);
    assign PENABLE     = (state == ACCESS);
    assign req0_rvalid = (state == RESP) && !gnt_id;
    assign req1_rvalid = (state == RESP) && gnt_id;

    // Transfer sequencing, request latch, timeout counter and response capture.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            gnt_id     <= 1'b0;
            rr_ptr     <= 1'b0;
            cnt        <= '0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req0_rdata <= '0;
            req0_err   <= 1'b0;
            req1_rdata <= '0;
            req1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_id <= sel_id;
                        PWRITE <= sel_id ? req1_write : req0_write;
                        PADDR  <= sel_id ? req1_addr  : req0_addr;
                        PWDATA <= sel_id ? req1_wdata : req0_wdata;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    cnt   <= '0;
                    state <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    // PREADY takes priority over a coincident timeout.
                    if (PREADY) begin
                        if (gnt_id) begin
                            req1_rdata <= PWRITE ? '0 : PRDATA;
                            req1_err   <= 1'b0;
                        end else begin
                            req0_rdata <= PWRITE ? '0 : PRDATA;
                            req0_err   <= 1'b0;
                        end
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        if (gnt_id) begin
                            req1_rdata <= '0;
                            req1_err   <= 1'b1;
                        end else begin
                            req0_rdata <= '0;
                            req0_err   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                default: begin
                    rr_ptr <= ~gnt_id;
                    cnt    <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_arbiter.sv
// Directed bench for apb_i2c_arbiter: reset values, single write, read with
// wait states, round-robin contention, PREADY timeout and async reset mid-ACCESS.
module tb_apb_i2c_arbiter;

    logic       PCLK;
    logic       PRESETn;
    logic       req0_valid, req0_write, req0_ready, req0_rvalid, req0_err;
    logic [7:0] req0_addr, req0_wdata, req0_rdata;
    logic       req1_valid, req1_write, req1_ready, req1_rvalid, req1_err;
    logic [7:0] req1_addr, req1_wdata, req1_rdata;
    logic       PSELx, PENABLE, PWRITE, PREADY;
    logic [7:0] PADDR, PWDATA, PRDATA;

    int tests = 0;
    int fails = 0;

    apb_i2c_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESETn    = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
        PREADY     = 1'b1; PRDATA = 8'h00;
        repeat (2) step();
        tests++;
        if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, req0_ready, req0_rvalid, req0_rdata, req0_err,
             req1_ready, req1_rvalid, req1_rdata, req1_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got sel=%b en=%b wr=%b addr=%h wd=%h r0=%b/%b/%h/%b r1=%b/%b/%h/%b, want all 0",
                     PSELx, PENABLE, PWRITE, PADDR, PWDATA, req0_ready, req0_rvalid, req0_rdata,
                     req0_err, req1_ready, req1_rvalid, req1_rdata, req1_err);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        PRESETn = 1'b1;
    endtask

    task automatic test_single_write();
        PREADY = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h02; req0_wdata = 8'hA5;
        #1;
        tests++;
        if (req0_ready !== 1'b1 || PSELx !== 1'b0) begin
            fails++;
            $display("FAIL wr_accept: got ready=%b sel=%b, want 1 0", req0_ready, PSELx);
        end
        step();
        req0_valid = 1'b0;
        tests++;
        if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 8'h02, 8'hA5}) begin
            fails++;
            $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h wd=%h, want 1 0 1 02 a5",
                     PSELx, PENABLE, PWRITE, PADDR, PWDATA);
        end
        step();
        tests++;
        if ({PSELx, PENABLE, PADDR, PWDATA, req0_rvalid} !== {1'b1, 1'b1, 8'h02, 8'hA5, 1'b0}) begin
            fails++;
            $display("FAIL wr_access: got sel=%b en=%b addr=%h wd=%h rv=%b, want 1 1 02 a5 0",
                     PSELx, PENABLE, PADDR, PWDATA, req0_rvalid);
        end
        step();
        tests++;
        if ({PSELx, PENABLE, req0_rvalid, req1_rvalid, req0_err, req0_rdata} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL wr_resp: got sel=%b en=%b rv0=%b rv1=%b err=%b rd=%h, want 0 0 1 0 0 00",
                     PSELx, PENABLE, req0_rvalid, req1_rvalid, req0_err, req0_rdata);
        end
        step();
        tests++;
        if ({req0_rvalid, PSELx} !== 2'b00) begin
            fails++;
            $display("FAIL wr_after: got rv0=%b sel=%b, want 0 0", req0_rvalid, PSELx);
        end
    endtask

    task automatic test_wait_read();
        int en_cnt;
        int addr_bad;
        PREADY = 1'b0; PRDATA = 8'h00;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h04; req1_wdata = 8'h99;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            fails++;
            $display("FAIL rd_accept: got %b, want 01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        tests++;
        if ({PSELx, PENABLE, PWRITE, PADDR} !== {1'b1, 1'b0, 1'b0, 8'h04}) begin
            fails++;
            $display("FAIL rd_setup: got sel=%b en=%b wr=%b addr=%h, want 1 0 0 04",
                     PSELx, PENABLE, PWRITE, PADDR);
        end
        en_cnt = 0;
        addr_bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (PENABLE === 1'b1) en_cnt++;
            if (PADDR !== 8'h04 || PSELx !== 1'b1) addr_bad++;
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 8'h3C;
            end
        end
        tests++;
        if (en_cnt !== 4 || addr_bad !== 0) begin
            fails++;
            $display("FAIL rd_wait: got penable_cycles=%0d addr_unstable=%0d, want 4 0", en_cnt, addr_bad);
        end
        step();
        PRDATA = 8'h00;
        tests++;
        if ({PENABLE, req1_rvalid, req0_rvalid, req1_rdata, req1_err} !== {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}) begin
            fails++;
            $display("FAIL rd_resp: got en=%b rv1=%b rv0=%b rd=%h err=%b, want 0 1 0 3c 0",
                     PENABLE, req1_rvalid, req0_rvalid, req1_rdata, req1_err);
        end
        step();
        tests++;
        if ({req1_rvalid, req1_rdata} !== {1'b0, 8'h3C}) begin
            fails++;
            $display("FAIL rd_hold: got rv1=%b rd=%h, want 0 3c", req1_rvalid, req1_rdata);
        end
    endtask

    task automatic test_contention();
        logic       exp_id;
        logic [7:0] exp_wd;
        int n0, n1;
        PRESETn = 1'b0;
        #2;
        step();
        PRESETn = 1'b1;
        PREADY = 1'b1;
        n0 = 0; n1 = 0;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h10; req0_wdata = 8'h00;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 8'h20; req1_wdata = 8'h80;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_id = k[0];
            exp_wd = exp_id ? (8'h80 + 8'(n1)) : 8'(n0);
            tests++;
            if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL rr_grant[%0d]: got %b, want %b", k, {req0_ready, req1_ready},
                         exp_id ? 2'b01 : 2'b10);
            end
            step();
            if (exp_id) begin
                n1++;
                req1_wdata = 8'h80 + 8'(n1);
                if (n1 == 4) req1_valid = 1'b0;
            end else begin
                n0++;
                req0_wdata = 8'(n0);
                if (n0 == 4) req0_valid = 1'b0;
            end
            tests++;
            if ({PSELx, PADDR, PWDATA} !== {1'b1, (exp_id ? 8'h20 : 8'h10), exp_wd}) begin
                fails++;
                $display("FAIL rr_setup[%0d]: got sel=%b addr=%h wd=%h, want 1 %h %h", k, PSELx,
                         PADDR, PWDATA, exp_id ? 8'h20 : 8'h10, exp_wd);
            end
            step();
            step();
            tests++;
            if ({req0_rvalid, req1_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL rr_route[%0d]: got %b, want %b", k, {req0_rvalid, req1_rvalid},
                         exp_id ? 2'b01 : 2'b10);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        int en_cnt;
        PREADY = 1'b0; PRDATA = 8'hFF;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h06;
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL to_accept: got %b, want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (PENABLE === 1'b1) en_cnt++;
            else break;
        end
        tests++;
        if (en_cnt !== 16) begin
            fails++;
            $display("FAIL to_cycles: got penable_cycles=%0d, want 16", en_cnt);
        end
        tests++;
        if ({PSELx, req0_rvalid, req1_rvalid, req0_err, req0_rdata} !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL to_resp: got sel=%b rv0=%b rv1=%b err=%b rd=%h, want 0 1 0 1 00",
                     PSELx, req0_rvalid, req1_rvalid, req0_err, req0_rdata);
        end
        step();
        PREADY = 1'b1; PRDATA = 8'h00;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h07; req0_wdata = 8'h11;
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL to_next_accept: got %b, want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        step();
        step();
        tests++;
        if ({req0_rvalid, req0_err, req0_rdata} !== {1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL to_next_resp: got rv0=%b err=%b rd=%h, want 1 0 00",
                     req0_rvalid, req0_err, req0_rdata);
        end
        step();
    endtask

    task automatic test_async_reset();
        PREADY = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h33; req0_wdata = 8'h44;
        step();
        req0_valid = 1'b0;
        step();
        step();
        tests++;
        if ({PSELx, PENABLE} !== 2'b11) begin
            fails++;
            $display("FAIL ar_in_access: got sel=%b en=%b, want 1 1", PSELx, PENABLE);
        end
        #2;
        PRESETn = 1'b0;
        #1;
        tests++;
        if ({PSELx, PENABLE, req0_rvalid, req1_rvalid, PADDR} !== 12'h000) begin
            fails++;
            $display("FAIL ar_immediate: got sel=%b en=%b rv0=%b rv1=%b addr=%h, want 0 0 0 0 00",
                     PSELx, PENABLE, req0_rvalid, req1_rvalid, PADDR);
        end
        step();
        PRESETn = 1'b1;
        PREADY = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h50; req0_wdata = 8'h01;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 8'h60; req1_wdata = 8'h02;
        #1;
        tests++;
        if ({req0_ready, req1_ready, req0_rvalid} !== 3'b100) begin
            fails++;
            $display("FAIL ar_first_grant: got rdy0=%b rdy1=%b rv0=%b, want 1 0 0",
                     req0_ready, req1_ready, req0_rvalid);
        end
        step();
        req0_valid = 1'b0;
        step();
        step();
        tests++;
        if ({req0_rvalid, req1_rvalid} !== 2'b10) begin
            fails++;
            $display("FAIL ar_resp: got %b, want 10", {req0_rvalid, req1_rvalid});
        end
        step();
        tests++;
        if (req1_ready !== 1'b1) begin
            fails++;
            $display("FAIL ar_second_grant: got %b, want 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wait_read();
        test_contention();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
